sprite_line_renderer: RTL and testbench
=======================================

Name: sprite_line_renderer

Overview:
- Scanline sprite engine that produces the 4-bit palette index per pixel, feeding color_palette_4bit directly.
- During display of line y it builds line y+1 into a ping-pong line buffer, fetching sprite rows from a synchronous sprite ROM.
- During active video it reads the front buffer at DrawX and clears each location as it is read.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; slot 0 has highest priority.
- SPR_W, 32, sprite width in pixels; must be a power of two.
- SPR_H, 32, sprite height in rows.
- H_ACTIVE, 640, visible pixels per line; this is also the line-buffer depth.
- ROM_AW, 14, sprite ROM address width.

Ports:
- Clk, in, 1: system clock; the only clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- line_start, in, 1: single-cycle pulse at the start of horizontal blank; swaps buffers and starts the build of next_y.
- next_y, in, 10: line to build; sampled on line_start.
- spr_en, in, NUM_SPRITES: per-slot enable.
- spr_x, in, NUM_SPRITES*10: left x per slot (flattened, slot 0 in LSBs).
- spr_y, in, NUM_SPRITES*10: top y per slot.
- spr_base, in, NUM_SPRITES*ROM_AW: ROM base address of each slot's image.
- rom_addr, out, ROM_AW: sprite ROM address.
- rom_data, in, 4: ROM index data; valid 1 cycle after rom_addr.
- pix_ce, in, 1: pixel-clock enable; one Clk per displayed pixel.
- blank, in, 1: high outside the active area.
- DrawX, in, 10: current pixel x.
- pix_index, out, 4: palette index to color_palette_4bit.
- busy, out, 1: build in progress.
- overrun, out, 1: sticky flag; a build was aborted by line_start. Cleared only by reset.

Behaviour:
- Reset values: pix_index=0, rom_addr=0, busy=0, overrun=0, front select=0, FSM=IDLE.
- Reset does not clear line-buffer RAM contents. The first two lines after reset are undefined; the bench ignores them.
- Buffers: two H_ACTIVE x 4 RAMs, each with one read port and one write port. The front buffer is read/cleared; the back buffer is built.
- Read path: on pix_ce & !blank, read front[DrawX]. pix_index is registered and valid 1 Clk later. front[DrawX] is written 0 in the same cycle.
- Read path, other cycles: on pix_ce & blank, pix_index<=0 and no clear. With pix_ce=0, pix_index holds.
- Every displayed line must read all H_ACTIVE pixels, so the buffer is clean when it returns as the back buffer.
- line_start: toggle the front select, latch next_y into ly, set busy=1, enter SCAN with slot i=NUM_SPRITES-1.
- line_start arriving while busy: set overrun=1, abort the current build, then proceed as above. The swap always occurs.
- FSM IDLE: wait for line_start.
- FSM SCAN: row r = ly - spr_y[i], 10-bit unsigned. If spr_en[i] and r < SPR_H, go to FETCH with col=0.
- FSM SCAN, miss: otherwise, if i==0 go to DONE, else decrement i and stay in SCAN (1 Clk per slot).
- FSM FETCH: rom_addr = spr_base[i] + r*SPR_W + col (truncated to ROM_AW). Increment col every Clk. After col=SPR_W-1 go to DRAIN.
- Write pipeline: the column and x for each fetch are delayed 1 Clk to align with rom_data.
- Write rule: write back[x] = rom_data only if rom_data != 0 (index 0 is transparent) and x = spr_x[i]+col < H_ACTIVE. x uses 11-bit arithmetic, so pixels at or past the right edge are discarded, never wrapped.
- FSM DRAIN: complete the final pending write (1 Clk). If i==0 go to DONE, else decrement i and go to SCAN.
- FSM DONE: busy<=0, go to IDLE.
- Priority: slots are processed from highest index down to 0, so lower slots overwrite higher ones.
- Worst-case build time: NUM_SPRITES*(SPR_W+2)+2 = 138 Clk. This is far less than a line period.
- Sprite inputs must stay stable while busy; changing them during a build is not supported.

Decomposition:
- Package sprite_pkg: typedef state_t {IDLE,SCAN,FETCH,DRAIN,DONE}; TRANSPARENT_IDX=4'h0; coordinate width constant COORD_W=10.
- Sub-module line_buffer_ram: parameterised depth/width, 1R1W, synchronous read. Instantiated twice.

Test Plan:
- Single sprite at (100,50) with ROM row 0 all 4'h5; line_start with next_y=50; next line reads DrawX 100..131 -> pix_index=5, others 0; busy high for NUM_SPRITES*... then low.
- Slot 0 at x=100 (4'h2) and slot 1 at x=110 (4'h7) both hit → x 100..131 = 2, x 132..141 = 7.
- Checkerboard row with alternate 0/4'h3 over slot 1 filled with 4'h9 → zeros show 9.
- Sprite at x=620 → only x 620..639 written; no write at x 0..11 (no wrap).
- spr_y=50 with next_y=49 and 82 → no pixels. Disabled slot at a hit position → no pixels.
- line_start pulsed 20 Clk after previous → overrun=1 and busy restarts.
- Reset_n low mid-FETCH → outputs 0 asynchronously and FSM IDLE.
- blank=1 → pix_index=0 and buffer contents preserved; a later unblanked read returns the stored index.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the scanline sprite renderer.
//   state_t          : build FSM states (exposed on the renderer debug port)
//   TRANSPARENT_IDX  : palette index that is never written into a line buffer
//   COORD_W          : width of every screen coordinate (x, y, row)
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam int         COORD_W         = 10;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Sprite ROM bus.
//   rom_addr : address driven by the renderer (master)
//   rom_data : 4-bit palette index returned by the ROM (slave)
// Timing contract: the ROM is synchronous; rom_data presented in cycle n+1
// belongs to the rom_addr presented in cycle n. There is no stall or
// backpressure, so every address is implicitly "valid" and always accepted.
interface sprite_line_renderer_if #(
    parameter int ROM_AW = 14
);
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer: one synchronous write port and one
// synchronous read port. A read and a write to the same address in the same
// cycle return the old contents (read-before-write), which lets the display
// side read a pixel and clear it in one cycle. Contents are not reset.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read port; rdata_o updates one cycle after re_i and
//                      holds its value while re_i is low
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// Scanline sprite engine. While line y is displayed from the front line
// buffer, line next_y is composed into the back buffer by fetching sprite rows
// from a synchronous ROM. line_start swaps the buffers.
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   line_start, next_y  : start building next_y (also swaps buffers)
//   spr_en/x/y/base     : per-slot sprite attributes, slot 0 in the LSBs
//   rom                 : sprite ROM bus (address out, data back 1 Clk later)
//   pix_ce, blank, DrawX: display-side pixel strobe, blanking and x position
//   pix_index           : palette index, valid 1 Clk after an unblanked pix_ce
//   busy, overrun       : build in progress / sticky build-aborted flag
//   dbg_state_o         : current build FSM state
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int H_ACTIVE    = 640,
    parameter int ROM_AW      = 14
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             line_start,
    input  logic [COORD_W-1:0]               next_y,
    input  logic [NUM_SPRITES-1:0]           spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0]   spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]   spr_y,
    input  logic [NUM_SPRITES*ROM_AW-1:0]    spr_base,
    sprite_line_renderer_if.master           rom,
    input  logic                             pix_ce,
    input  logic                             blank,
    input  logic [COORD_W-1:0]               DrawX,
    output logic [3:0]                       pix_index,
    output logic                             busy,
    output logic                             overrun,
    output state_t                           dbg_state_o
);

    localparam int CW  = $clog2(SPR_W);
    localparam int IW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int BAW = $clog2(H_ACTIVE);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        col_q, col_d;
    logic [COORD_W-1:0]   ly_q;
    logic                 fsel_q;
    logic                 busy_q;
    logic                 overrun_q;
    logic                 wr_v_q;
    logic [COORD_W:0]     wr_x_q;
    logic                 pix_zero_q;
    logic                 rd_buf_q;

    // Attributes of the slot currently being scanned or fetched.
    logic [COORD_W-1:0]   cur_x, cur_y, row;
    logic [ROM_AW-1:0]    cur_base;
    logic                 hit;
    logic [COORD_W:0]     fetch_x;

    assign cur_x    = spr_x[idx_q*COORD_W +: COORD_W];
    assign cur_y    = spr_y[idx_q*COORD_W +: COORD_W];
    assign cur_base = spr_base[idx_q*ROM_AW +: ROM_AW];
    // Unsigned wrap makes lines above the sprite appear as huge rows (misses).
    assign row      = ly_q - cur_y;
    assign hit      = spr_en[idx_q] && (row < COORD_W'(SPR_H));
    // One extra bit so pixels past the right edge are dropped, not wrapped.
    assign fetch_x  = {1'b0, cur_x} + (COORD_W+1)'(col_q);

    assign rom.rom_addr = (state_q == FETCH)
                        ? cur_base + (ROM_AW'(row) << CW) + ROM_AW'(col_q)
                        : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        case (state_q)
            IDLE: ;
            SCAN: begin
                if (hit) begin
                    state_d = FETCH;
                    col_d   = '0;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            FETCH: begin
                col_d = col_q + 1'b1;
                if (col_q == CW'(SPR_W-1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new line always wins, aborting whatever build is in flight.
        if (line_start) begin
            state_d = SCAN;
            idx_d   = IW'(NUM_SPRITES-1);
            col_d   = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            col_q      <= '0;
            ly_q       <= '0;
            fsel_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            wr_v_q     <= 1'b0;
            wr_x_q     <= '0;
            pix_zero_q <= 1'b1;
            rd_buf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            // Delay x by one cycle so it lines up with rom_data.
            wr_v_q  <= (state_q == FETCH) && !line_start;
            wr_x_q  <= fetch_x;
            if (line_start) begin
                fsel_q <= ~fsel_q;
                ly_q   <= next_y;
                busy_q <= 1'b1;
                if (busy_q) begin
                    overrun_q <= 1'b1;
                end
            end else if (state_q == DONE) begin
                busy_q <= 1'b0;
            end
            if (pix_ce) begin
                pix_zero_q <= blank;
                if (!blank) begin
                    rd_buf_q <= fsel_q;
                end
            end
        end
    end

    // Build-side write: skip transparent pixels and anything off-screen.
    logic bld_we;
    logic clr_we;
    assign bld_we = wr_v_q && !line_start && (rom.rom_data != TRANSPARENT_IDX)
                 && (wr_x_q < (COORD_W+1)'(H_ACTIVE));
    assign clr_we = pix_ce && !blank;

    logic [3:0] rd_data [2];

    for (genvar b = 0; b < 2; b++) begin : gen_buf
        logic is_front;
        assign is_front = (fsel_q == 1'(b));

        line_buffer_ram #(
            .DEPTH (H_ACTIVE),
            .WIDTH (4),
            .AW    (BAW)
        ) u_ram (
            .clk_i   (Clk),
            .we_i    (is_front ? clr_we : bld_we),
            .waddr_i (is_front ? BAW'(DrawX) : wr_x_q[BAW-1:0]),
            .wdata_i (is_front ? TRANSPARENT_IDX : rom.rom_data),
            .re_i    (is_front && clr_we),
            .raddr_i (BAW'(DrawX)),
            .rdata_o (rd_data[b])
        );
    end

    // The RAM output register holds between reads, so the output is either
    // that register or a forced zero after a blanked pixel strobe.
    assign pix_index   = pix_zero_q ? TRANSPARENT_IDX : rd_data[rd_buf_q];
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;
  import sprite_pkg::*;

  localparam int NS = 4;
  localparam int SW = 32;
  localparam int SH = 32;
  localparam int HA = 640;
  localparam int AW = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              line_start = 1'b0;
  logic [9:0]        next_y = '0;
  logic [NS-1:0]     spr_en = '0;
  logic [NS*10-1:0]  spr_x = '0;
  logic [NS*10-1:0]  spr_y = '0;
  logic [NS*AW-1:0]  spr_base = '0;
  logic              pix_ce = 1'b0;
  logic              blank = 1'b1;
  logic [9:0]        draw_x = '0;
  logic [3:0]        pix_index;
  logic              busy;
  logic              overrun;
  state_t            dbg_state;

  sprite_line_renderer_if #(.ROM_AW(AW)) rom_if ();

  sprite_line_renderer #(
    .NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .H_ACTIVE(HA), .ROM_AW(AW)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .line_start(line_start), .next_y(next_y),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
    .rom(rom_if), .pix_ce(pix_ce), .blank(blank), .DrawX(draw_x),
    .pix_index(pix_index), .busy(busy), .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // Synchronous sprite ROM model
  logic [3:0] rom_mem [1<<AW];
  always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  // ---------------- reference model ----------------
  int c_en[NS], c_x[NS], c_y[NS], c_base[NS];
  int front_line[HA];
  int next_line[HA];
  int valid_cnt = 0;

  // Per pixel: the lowest-numbered enabled slot covering it with an opaque pixel wins.
  function automatic void model_line(input int y);
    for (int x = 0; x < HA; x++) begin
      int v;
      v = 0;
      for (int s = 0; s < NS; s++) begin
        int r;
        int c;
        r = (y - c_y[s]) & 1023;
        c = x - c_x[s];
        if (v == 0 && c_en[s] != 0 && r < SH && c >= 0 && c < SW)
          v = int'(rom_mem[(c_base[s] + r*SW + c) % (1<<AW)]);
      end
      next_line[x] = v;
    end
  endfunction

  function automatic int count_hits(input int y);
    int h;
    h = 0;
    for (int s = 0; s < NS; s++)
      if (c_en[s] != 0 && ((y - c_y[s]) & 1023) < SH) h++;
    return h;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [14:0] exp_q[$];   // {x[10:0], expected pix_index}
  bit trk = 1'b0;
  bit chk_pend = 1'b0;
  logic [3:0] last_exp = '0;

  task automatic check(input string name, input int x, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (x=%0d): got %0h expected %0h at %0t", name, x, act, exp, $time);
    end
  endtask

  always @(posedge clk) chk_pend <= trk;

  always @(negedge clk) begin
    if (chk_pend) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", -1, 32'd1, 32'd0);
      end else begin
        logic [14:0] ent;
        ent = exp_q.pop_front();
        check("pix_index", int'(ent[14:4]), 32'(pix_index), 32'(ent[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_cfg();
    for (int s = 0; s < NS; s++) begin
      spr_en[s]            = (c_en[s] != 0);
      spr_x[s*10 +: 10]    = 10'(c_x[s]);
      spr_y[s*10 +: 10]    = 10'(c_y[s]);
      spr_base[s*AW +: AW] = AW'(c_base[s]);
    end
  endtask

  task automatic clear_cfg();
    for (int s = 0; s < NS; s++) begin
      c_en[s] = 0; c_x[s] = 0; c_y[s] = 0; c_base[s] = 0;
    end
  endtask

  task automatic drive_cyc(input bit ce, input bit bl, input int x, input bit tracked, input logic [3:0] e);
    @(posedge clk); #1;
    line_start = 1'b0;
    pix_ce = ce;
    blank = bl;
    draw_x = 10'(x);
    trk = tracked;
    if (tracked) exp_q.push_back({11'(x), e});
  endtask

  task automatic display_line(input bit chk);
    logic [3:0] e;
    for (int x = 0; x < HA; x++) begin
      if ($urandom_range(0, 7) == 0) drive_cyc(1'b0, 1'b0, x, chk, last_exp);
      if ($urandom_range(0, 15) == 0) begin
        drive_cyc(1'b1, 1'b1, x, chk, 4'h0);
        last_exp = 4'h0;
      end
      e = chk ? 4'(front_line[x]) : 4'h0;
      drive_cyc(1'b1, 1'b0, x, chk, e);
      last_exp = e;
    end
    for (int k = 0; k < 8; k++) begin
      drive_cyc(1'b1, 1'b1, 0, chk, 4'h0);
      last_exp = 4'h0;
    end
    drive_cyc(1'b0, 1'b1, 0, 1'b0, 4'h0);
  endtask

  // Build line y with the current config while displaying the previous build.
  task automatic run_line(input int y);
    int exp_busy;
    bit chk;
    apply_cfg();
    model_line(y);
    exp_busy = NS + count_hits(y) * (SW + 1) + 1;
    chk = (valid_cnt >= 2);
    @(posedge clk); #1;
    line_start = 1'b1;
    next_y = 10'(y);
    pix_ce = 1'b0;
    trk = 1'b0;
    fork
      begin
        int cnt;
        cnt = 0;
        @(posedge clk);
        @(negedge clk);
        while (busy === 1'b1 && cnt < 400) begin
          cnt++;
          @(negedge clk);
        end
        check("busy_cycles", y, 32'(cnt), 32'(exp_busy));
      end
      display_line(chk);
    join
    check("overrun_clear", y, 32'(overrun), 32'd0);
    front_line = next_line;
    valid_cnt++;
  endtask

  task automatic rand_cfg(input int yl);
    for (int s = 0; s < NS; s++) begin
      c_en[s]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c_x[s]    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
      c_y[s]    = (yl - int'($urandom_range(0, 40)) + 1024) % 1024;
      c_base[s] = int'($urandom_range(0, (1<<AW) - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_index"}, -1, 32'(pix_index), 32'd0);
    check({tag, "_busy"}, -1, 32'(busy), 32'd0);
    check({tag, "_overrun"}, -1, 32'(overrun), 32'd0);
    check({tag, "_rom_addr"}, -1, 32'(rom_if.rom_addr), 32'd0);
    check({tag, "_state"}, -1, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int yl;
    int r;
    for (int a = 0; a < (1<<AW); a++)
      rom_mem[a] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    for (int a = 0; a < 1024; a++) begin
      rom_mem[16'h0000 + a] = 4'h5;
      rom_mem[16'h0400 + a] = 4'h2;
      rom_mem[16'h0800 + a] = 4'h7;
      rom_mem[16'h0C00 + a] = (a % 2 == 0) ? 4'h0 : 4'h3;
      rom_mem[16'h1000 + a] = 4'h9;
    end
    clear_cfg();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two lines to flush undefined buffer contents after reset
    run_line(0);
    run_line(0);

    // Single sprite, row 0 all 5
    c_en[0] = 1; c_x[0] = 100; c_y[0] = 50; c_base[0] = 16'h0000;
    run_line(50);
    // Two overlapping sprites, slot 0 on top
    c_en[0] = 1; c_x[0] = 100; c_y[0] = 50; c_base[0] = 16'h0400;
    c_en[1] = 1; c_x[1] = 110; c_y[1] = 50; c_base[1] = 16'h0800;
    run_line(50);
    // Checkerboard over a solid sprite: transparent holes show slot 1
    c_en[0] = 1; c_x[0] = 200; c_y[0] = 10; c_base[0] = 16'h0C00;
    c_en[1] = 1; c_x[1] = 200; c_y[1] = 10; c_base[1] = 16'h1000;
    run_line(20);
    // Right-edge clipping, no wrap to x=0
    clear_cfg();
    c_en[0] = 1; c_x[0] = 620; c_y[0] = 50; c_base[0] = 16'h0000;
    run_line(60);
    // Lines just above and just below the sprite
    c_x[0] = 300;
    run_line(49);
    run_line(82);
    // Disabled slot at a hit position
    c_en[0] = 0;
    run_line(50);

    for (int n = 0; n < 16; n++) begin
      yl = int'($urandom_range(0, 479));
      rand_cfg(yl);
      run_line(yl);
    end
    clear_cfg();
    run_line(0);

    // Overrun: second line_start 20 Clk after the first while still building
    c_en[3] = 1; c_x[3] = 40; c_y[3] = 100; c_base[3] = 16'h0123;
    apply_cfg();
    @(posedge clk); #1;
    line_start = 1'b1; next_y = 10'd105;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    line_start = 1'b1; next_y = 10'd110;
    @(posedge clk); #1;
    line_start = 1'b0;
    @(negedge clk);
    check("overrun_set", -1, 32'(overrun), 32'd1);
    check("overrun_busy", -1, 32'(busy), 32'd1);
    check("overrun_state_scan", -1, 32'(dbg_state), 32'(SCAN));
    repeat (5) @(negedge clk);
    r = (110 - 100) & 1023;
    check("fetch_state", -1, 32'(dbg_state), 32'(FETCH));
    check("fetch_rom_addr", -1, 32'(rom_if.rom_addr), 32'((16'h0123 + r*SW + 4) % (1<<AW)));

    // Asynchronous reset in the middle of a fetch
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_cnt = 0;

    clear_cfg();
    run_line(0);
    run_line(0);
    for (int n = 0; n < 4; n++) begin
      yl = int'($urandom_range(0, 479));
      rand_cfg(yl);
      run_line(yl);
    end
    clear_cfg();
    run_line(0);

    repeat (3) @(posedge clk);
    check("sb_drained", -1, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
